// File: rtl/fp_rf_pkg.sv
// fp_rf_pkg: shared constants and NaN-boxing helpers for the FP register file.
package fp_rf_pkg;
  localparam logic [31:0] CANON_NAN_S = 32'h7FC0_0000;
  localparam logic [31:0] BOX_ONES = 32'hFFFF_FFFF;
  localparam int FLEN_S = 32;
  localparam int FLEN_D = 64;

  function automatic logic [63:0] nan_box(input logic [63:0] data, input logic sp);
    return sp ? {BOX_ONES, data[31:0]} : data;
  endfunction

  function automatic logic [63:0] nan_unbox(input logic [63:0] data, input logic sp);
    return (sp && data[63:32] != BOX_ONES) ? {BOX_ONES, CANON_NAN_S} : data;
  endfunction
endpackage

// File: rtl/fp_rf_unbox.sv
// fp_rf_unbox: one read port, forwarding committing writes and unboxing single-precision reads.
module fp_rf_unbox
  import fp_rf_pkg::*;
#(
  parameter int FLEN = 64,
  parameter int AW = 5,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]   addr,
  input  logic            sp,
  input  logic [FLEN-1:0] stored,
  input  logic            wa_en,
  input  logic [AW-1:0]   wa_addr,
  input  logic [FLEN-1:0] wa_box,
  input  logic            wb_fire,
  input  logic [AW-1:0]   wb_addr,
  input  logic [FLEN-1:0] wb_box,
  output logic [FLEN-1:0] data
);
  logic [FLEN-1:0] src;
  logic [63:0] raw;
  always_comb begin
    src = (BYPASS != 0 && wa_en && wa_addr == addr) ? wa_box :
          (BYPASS != 0 && wb_fire && wb_addr == addr) ? wb_box : stored;
    raw = nan_unbox(64'(src), sp && FLEN == FLEN_D);
    data = raw[FLEN-1:0];
  end
endmodule

// File: rtl/fp_regfile_nb.sv
// fp_regfile_nb: FP register file with NaN-boxing, two write ports, pending scoreboard and FS-dirty flag.
module fp_regfile_nb
  import fp_rf_pkg::*;
#(
  parameter int FLEN = 64,
  parameter int NREGS = 32,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  input  logic [AW-1:0]    rs3_addr,
  input  logic [2:0]       rs_sp,
  output logic [FLEN-1:0]  rs1_data,
  output logic [FLEN-1:0]  rs2_data,
  output logic [FLEN-1:0]  rs3_data,
  input  logic             wa_en,
  input  logic [AW-1:0]    wa_addr,
  input  logic [FLEN-1:0]  wa_data,
  input  logic             wa_sp,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_addr,
  input  logic [FLEN-1:0]  wb_data,
  input  logic             wb_sp,
  output logic             wb_ready,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  output logic [NREGS-1:0] busy,
  input  logic             fs_clean,
  output logic             fs_dirty
);
  logic [FLEN-1:0] rf [NREGS];
  logic [63:0] wa_box64, wb_box64;
  logic [FLEN-1:0] wa_box, wb_box;
  logic wb_fire;
  logic [NREGS-1:0] busy_nxt;
  logic [AW-1:0] ra [3];
  logic [FLEN-1:0] rd [3];
  // Port B yields to port A only on an address clash; never depends on wb_valid.
  assign wb_ready = !(wa_en && wa_addr == wb_addr);
  assign wb_fire = wb_valid && wb_ready;
  assign wa_box64 = nan_box(64'(wa_data), wa_sp && FLEN == FLEN_D);
  assign wb_box64 = nan_box(64'(wb_data), wb_sp && FLEN == FLEN_D);
  assign wa_box = wa_box64[FLEN-1:0];
  assign wb_box = wb_box64[FLEN-1:0];
  assign ra = '{rs1_addr, rs2_addr, rs3_addr};
  for (genvar i = 0; i < 3; i++) begin : g_rd
    fp_rf_unbox #(.FLEN(FLEN), .AW(AW), .BYPASS(BYPASS)) u_unbox (
      .addr(ra[i]), .sp(rs_sp[i]), .stored(rf[ra[i]]),
      .wa_en(wa_en), .wa_addr(wa_addr), .wa_box(wa_box),
      .wb_fire(wb_fire), .wb_addr(wb_addr), .wb_box(wb_box),
      .data(rd[i])
    );
  end
  assign rs1_data = rd[0];
  assign rs2_data = rd[1];
  assign rs3_data = rd[2];
  // A newly issued producer supersedes any commit to the same register.
  always_comb begin
    busy_nxt = busy & ~((wa_en ? NREGS'(1) << wa_addr : '0) | (wb_fire ? NREGS'(1) << wb_addr : '0));
    busy_nxt = busy_nxt | (iss_en ? NREGS'(1) << iss_addr : '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NREGS; n++) rf[n] <= '0;
      busy <= '0;
      fs_dirty <= 1'b0;
    end else begin
      if (wb_fire) rf[wb_addr] <= wb_box;
      if (wa_en) rf[wa_addr] <= wa_box;
      busy <= busy_nxt;
      fs_dirty <= wa_en || wb_fire || (fs_dirty && !fs_clean);
    end
  end
endmodule
